// File: rtl/gpu_sprite_engine_pkg.sv
// Shared constants and state encoding for the CHIP-8-style sprite blitter.
package gpu_sprite_engine_pkg;

  localparam int unsigned SCREEN_WIDTH         = 64;
  localparam int unsigned SCREEN_HEIGHT        = 32;
  localparam int unsigned SCREEN_BYTES_PER_ROW = 8;
  localparam logic [15:0] SCREEN_BASE_DEFAULT  = 16'h0F00;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH_RD,
    ST_FETCH_LATCH,
    ST_LEFT_RD,
    ST_LEFT_LATCH,
    ST_LEFT_WR,
    ST_RIGHT_RD,
    ST_RIGHT_LATCH,
    ST_RIGHT_WR
  } state_t;

endpackage

// File: rtl/gpu_sprite_engine.sv
// Sprite blitter: XORs sprite bytes from shared memory onto a 64x32
// monochrome framebuffer in the same memory. Bus outputs are zero whenever
// the matching strobe is low so they can be ORed with another master.
module gpu_sprite_engine
  import gpu_sprite_engine_pkg::*;
#(
  parameter logic [15:0] SCREEN_BASE = SCREEN_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        draw,
  input  logic [15:0] addr,
  input  logic [3:0]  lines,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic        ready,
  output logic        collision,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_write_byte,
  input  logic [7:0]  mem_read_byte
);

  localparam int unsigned X_W   = $clog2(SCREEN_WIDTH);
  localparam int unsigned ROW_W = $clog2(SCREEN_HEIGHT);
  localparam int unsigned COL_W = $clog2(SCREEN_BYTES_PER_ROW);

  state_t            state, state_n;
  logic [15:0]       base_r, base_n;
  logic [3:0]        lines_r, lines_n;
  logic [X_W-1:0]    x_r, x_n;
  logic [ROW_W-1:0]  y_r, y_n;
  logic [3:0]        cnt_r, cnt_n;
  logic [7:0]        sprite_r, sprite_n;
  logic              coll_n;
  logic              ready_n;
  logic              read_n;
  logic              write_n;
  logic [15:0]       addr_n;
  logic [7:0]        wbyte_n;
  logic              accept;
  logic              line_done;
  logic [ROW_W-1:0]  row_n;
  logic [COL_W-1:0]  col_n;
  logic [2:0]        sh;
  logic [15:0]       pat;
  logic              unused_bits;

  assign unused_bits = ^{x[7:X_W], y[7:ROW_W]};

  // Byte address of (row, byte column) inside the framebuffer.
  function automatic logic [15:0] screen_addr(input logic [ROW_W-1:0] row,
                                              input logic [COL_W-1:0] col);
    return SCREEN_BASE + 16'({row, col});
  endfunction

  // Shifting {S,0} right by sh yields the left-byte pattern in the upper
  // half and the (S << (8-sh)) right-byte spill in the lower half.
  function automatic logic [15:0] split_pattern(input logic [7:0] s,
                                                input logic [2:0] shift);
    return {s, 8'h00} >> shift;
  endfunction

  assign sh  = x_r[2:0];
  assign pat = split_pattern(sprite_r, sh);

  // Next state, latched draw parameters and next registered bus outputs.
  // Outputs are derived from the upcoming state so each strobe appears in
  // the cycle whose name it carries.
  always_comb begin
    state_n   = state;
    base_n    = base_r;
    lines_n   = lines_r;
    x_n       = x_r;
    y_n       = y_r;
    cnt_n     = cnt_r;
    sprite_n  = sprite_r;
    coll_n    = collision;
    accept    = 1'b0;
    line_done = 1'b0;
    read_n    = 1'b0;
    write_n   = 1'b0;
    addr_n    = '0;
    wbyte_n   = '0;

    case (state)
      ST_IDLE: begin
        if (draw && ready) begin
          accept  = 1'b1;
          base_n  = addr;
          lines_n = lines;
          x_n     = x[X_W-1:0];
          y_n     = y[ROW_W-1:0];
          cnt_n   = '0;
          coll_n  = 1'b0;
          if (lines != 4'd0) state_n = ST_FETCH_RD;
        end
      end
      ST_FETCH_RD:    state_n = ST_FETCH_LATCH;
      ST_FETCH_LATCH: begin
        sprite_n = mem_read_byte;
        state_n  = ST_LEFT_RD;
      end
      ST_LEFT_RD:     state_n = ST_LEFT_LATCH;
      ST_LEFT_LATCH: begin
        coll_n  = collision | (|(mem_read_byte & pat[15:8]));
        state_n = ST_LEFT_WR;
      end
      ST_LEFT_WR: begin
        if (sh != 3'd0) state_n = ST_RIGHT_RD;
        else            line_done = 1'b1;
      end
      ST_RIGHT_RD:    state_n = ST_RIGHT_LATCH;
      ST_RIGHT_LATCH: begin
        coll_n  = collision | (|(mem_read_byte & pat[7:0]));
        state_n = ST_RIGHT_WR;
      end
      ST_RIGHT_WR:    line_done = 1'b1;
      default:        state_n = ST_IDLE;
    endcase

    if (line_done) begin
      if (cnt_r == lines_r - 4'd1) begin
        state_n = ST_IDLE;
      end else begin
        cnt_n   = cnt_r + 4'd1;
        state_n = ST_FETCH_RD;
      end
    end

    row_n   = y_n + ROW_W'(cnt_n);
    col_n   = x_n[X_W-1:3];
    ready_n = (state_n == ST_IDLE) && !accept;

    case (state_n)
      ST_FETCH_RD: begin
        read_n = 1'b1;
        addr_n = base_n + 16'(cnt_n);
      end
      ST_LEFT_RD: begin
        read_n = 1'b1;
        addr_n = screen_addr(row_n, col_n);
      end
      ST_LEFT_WR: begin
        write_n = 1'b1;
        addr_n  = screen_addr(row_n, col_n);
        wbyte_n = mem_read_byte ^ pat[15:8];
      end
      ST_RIGHT_RD: begin
        read_n = 1'b1;
        addr_n = screen_addr(row_n, col_n + COL_W'(1));
      end
      ST_RIGHT_WR: begin
        write_n = 1'b1;
        addr_n  = screen_addr(row_n, col_n + COL_W'(1));
        wbyte_n = mem_read_byte ^ pat[7:0];
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Latched draw parameters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_r         <= '0;
      lines_r        <= '0;
      x_r            <= '0;
      y_r            <= '0;
      cnt_r          <= '0;
      sprite_r       <= '0;
      collision      <= 1'b0;
      ready          <= 1'b1;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_addr       <= '0;
      mem_write_byte <= '0;
    end else begin
      base_r         <= base_n;
      lines_r        <= lines_n;
      x_r            <= x_n;
      y_r            <= y_n;
      cnt_r          <= cnt_n;
      sprite_r       <= sprite_n;
      collision      <= coll_n;
      ready          <= ready_n;
      mem_read       <= read_n;
      mem_write      <= write_n;
      mem_addr       <= addr_n;
      mem_write_byte <= wbyte_n;
    end
  end

endmodule

// File: tb/tb_gpu_sprite_engine.sv
// Self-checking bench for gpu_sprite_engine: byte memory peer, pixel-level
// framebuffer model, per-cycle bus checker and directed draw scenarios.
module tb_gpu_sprite_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        draw;
  logic [15:0] addr;
  logic [3:0]  lines;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        ready;
  logic        collision;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [7:0]  mem_write_byte;
  logic [7:0]  mem_read_byte;

  logic [7:0]  mem [0:65535];
  bit          fb [0:31][0:63];
  int          compared = 0;
  int          mismatched = 0;
  int          strobe_cnt = 0;
  bit          checking = 1'b0;

  gpu_sprite_engine #(.SCREEN_BASE(16'h0F00)) dut (
    .clk(clk), .reset(reset), .draw(draw), .addr(addr), .lines(lines),
    .x(x), .y(y), .ready(ready), .collision(collision),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_write_byte(mem_write_byte), .mem_read_byte(mem_read_byte)
  );

  always #5 clk = ~clk;

  // Byte memory peer: read data valid the cycle after the strobe, held.
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_write_byte;
    if (mem_read)  mem_read_byte <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle bus rules.
  always @(negedge clk) begin
    if (checking) begin
      check("one_strobe", 32'(mem_read & mem_write), 32'd0);
      if (!mem_read && !mem_write) check("idle_addr", 32'(mem_addr), 32'd0);
      if (!mem_write) check("idle_wdata", 32'(mem_write_byte), 32'd0);
      if (mem_write) check("write_in_screen", 32'(mem_addr[15:8]), 32'h0F);
      if (mem_read || mem_write) strobe_cnt++;
    end
  end

  task automatic clear_screen();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 64; c++) fb[r][c] = 1'b0;
    for (int k = 0; k < 256; k++) mem[16'h0F00 + k] = 8'h00;
  endtask

  // Pixel-level reference: flip each lit sprite pixel with toroidal wrap.
  task automatic model_draw(input logic [15:0] a, input logic [3:0] n,
                            input logic [7:0] xx, input logic [7:0] yy, output bit coll);
    logic [7:0] s;
    int px, py;
    coll = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      s = mem[16'(a + 16'(i))];
      py = (int'(yy[4:0]) + i) % 32;
      for (int b = 0; b < 8; b++) begin
        if (s[7-b]) begin
          px = (int'(xx[5:0]) + b) % 64;
          if (fb[py][px]) coll = 1'b1;
          fb[py][px] = ~fb[py][px];
        end
      end
    end
  endtask

  task automatic check_screen();
    logic [7:0] e;
    for (int k = 0; k < 256; k++) begin
      for (int b = 0; b < 8; b++) e[7-b] = fb[k/8][(k%8)*8 + b];
      check($sformatf("screen[%0h]", 16'h0F00 + k), 32'(mem[16'h0F00 + k]), 32'(e));
    end
  endtask

  task automatic do_draw(input logic [15:0] a, input logic [3:0] n,
                         input logic [7:0] xx, input logic [7:0] yy,
                         input bit poke, output int busy);
    bit ec;
    int s0, exp_busy, exp_str;
    model_draw(a, n, xx, yy, ec);
    exp_busy = (n == 0) ? 1 : int'(n) * ((xx[2:0] != 0) ? 8 : 5);
    exp_str  = int'(n) * ((xx[2:0] != 0) ? 5 : 3);
    @(negedge clk);
    s0 = strobe_cnt;
    addr = a; lines = n; x = xx; y = yy; draw = 1'b1;
    @(negedge clk);
    draw = 1'b0;
    busy = 0;
    while (!ready && busy < 200) begin
      busy++;
      if (poke && busy == 2) begin
        draw = 1'b1; addr = 16'h0300; lines = 4'd3; x = 8'd9; y = 8'd3;
      end else begin
        draw = 1'b0;
      end
      @(negedge clk);
    end
    draw = 1'b0;
    check("busy_cycles", 32'(busy), 32'(exp_busy));
    check("strobes", 32'(strobe_cnt - s0), 32'(exp_str));
    check("collision", 32'(collision), 32'(ec));
    check_screen();
  endtask

  initial begin
    int busy, s0;
    reset = 1'b1; draw = 1'b0; addr = '0; lines = '0; x = '0; y = '0;
    for (int k = 0; k < 65536; k++) mem[k] = 8'h00;
    for (int k = 0; k < 3; k++) mem[16'h0300 + k] = 8'hAA;
    clear_screen();
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_collision", 32'(collision), 32'd0);
    check("rst_read", 32'(mem_read), 32'd0);
    check("rst_write", 32'(mem_write), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_write_byte), 32'd0);
    reset = 1'b0;
    checking = 1'b1;

    // Single line, byte-aligned, then the same draw again to erase.
    mem[16'h0200] = 8'hF0;
    do_draw(16'h0200, 4'd1, 8'd0, 8'd0, 1'b0, busy);
    check("t1_byte", 32'(mem[16'h0F00]), 32'hF0);
    check("t1_busy", 32'(busy), 32'd5);
    check("t1_coll", 32'(collision), 32'd0);
    do_draw(16'h0200, 4'd1, 8'd0, 8'd0, 1'b0, busy);
    check("t2_byte", 32'(mem[16'h0F00]), 32'h00);
    check("t2_coll", 32'(collision), 32'd1);

    // Zero lines: one busy cycle, no bus traffic, collision cleared.
    do_draw(16'h0200, 4'd0, 8'd5, 8'd7, 1'b0, busy);
    check("t6_busy", 32'(busy), 32'd1);
    check("t6_coll", 32'(collision), 32'd0);

    // Unaligned x with a draw pulse while busy that must be ignored.
    clear_screen();
    mem[16'h0200] = 8'hFF;
    do_draw(16'h0200, 4'd1, 8'd4, 8'd1, 1'b1, busy);
    check("t3_left", 32'(mem[16'h0F08]), 32'h0F);
    check("t3_right", 32'(mem[16'h0F09]), 32'hF0);
    check("t3_busy", 32'(busy), 32'd8);

    // Horizontal wrap; upper x/y bits set and ignored.
    clear_screen();
    do_draw(16'h0200, 4'd1, 8'hFC, 8'hE0, 1'b0, busy);
    check("t4_left", 32'(mem[16'h0F07]), 32'h0F);
    check("t4_wrap", 32'(mem[16'h0F00]), 32'hF0);

    // Vertical wrap.
    clear_screen();
    mem[16'h0200] = 8'h80; mem[16'h0201] = 8'h80;
    do_draw(16'h0200, 4'd2, 8'd0, 8'd31, 1'b0, busy);
    check("t5_row31", 32'(mem[16'h0FF8]), 32'h80);
    check("t5_row0", 32'(mem[16'h0F00]), 32'h80);

    // Tall sprite over existing pixels, then sprite address wrap at 0xFFFF.
    for (int k = 0; k < 15; k++) mem[16'h0210 + k] = 8'(8'h3C ^ (k * 37));
    do_draw(16'h0210, 4'd15, 8'd37, 8'd25, 1'b0, busy);
    do_draw(16'h0210, 4'd7, 8'd61, 8'd28, 1'b0, busy);
    mem[16'hFFFC] = 8'hC3; mem[16'hFFFD] = 8'h5A; mem[16'hFFFE] = 8'h81;
    mem[16'hFFFF] = 8'h7E; mem[16'h0000] = 8'h99; mem[16'h0001] = 8'hE7;
    do_draw(16'hFFFC, 4'd6, 8'd13, 8'd20, 1'b0, busy);

    // Reset in the middle of a draw aborts with no further accesses.
    clear_screen();
    mem[16'h0200] = 8'hFF;
    @(negedge clk);
    addr = 16'h0200; lines = 4'd4; x = 8'd3; y = 8'd2; draw = 1'b1;
    @(negedge clk);
    draw = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_read", 32'(mem_read), 32'd0);
    check("mid_rst_write", 32'(mem_write), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0;
    s0 = strobe_cnt;
    repeat (6) @(negedge clk);
    check("mid_rst_quiet", 32'(strobe_cnt - s0), 32'd0);
    check_screen();

    do_draw(16'h0200, 4'd1, 8'd0, 8'd0, 1'b0, busy);
    check("post_rst_byte", 32'(mem[16'h0F00]), 32'hFF);

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
